game_board_engine: RTL

Parametrised N×N sliding-tile (2048-style) board engine; the next generation of the game core behind the VGA top level. It replaces the fixed 4×4 debug FSM. It owns the tile matrix, executes direction moves with standard merge rules, spawns new tiles from a free-running LFSR, and tracks score and win/lose. It runs in the 25 MHz pixel-clock domain, and the board interpreter reads the flattened `board` bus directly.

---
 rtl/game_board_engine.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/game_board_engine.sv
// N x N sliding-tile (2048-style) board engine: moves, merges, LFSR spawns, score and win/lose.
// Optional GAME_SPAWN_FOUR_EN: spawns exponent 2 when LFSR[2:0] == 0 at spawn entry.
module game_board_engine #(
    parameter int          N         = 4,
    parameter int          TILE_W    = 4,
    parameter int          WIN_EXP   = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk_25Mhz,
    input  logic                     reset,
    input  logic                     mov_left,
    input  logic                     mov_right,
    input  logic                     mov_up,
    input  logic                     mov_down,
    input  logic                     load_en,
    input  logic [N*N*TILE_W-1:0]    load_board,
    output logic [N*N*TILE_W-1:0]    board,
    output logic [15:0]              score,
    output logic                     win_flag,
    output logic                     lose_flag,
    output logic                     busy,
    output logic                     move_done,
    output logic [2:0]               dbg_state
);
    localparam int CELLS = N * N;
    localparam int LW    = $clog2(N);
    localparam int CW    = $clog2(CELLS);
    localparam logic [TILE_W-1:0] MAX_EXP = '1;
    localparam logic [TILE_W-1:0] WIN_T   = TILE_W'(WIN_EXP);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_SHIFT, S_CHECK, S_SPAWN, S_EVAL} state_t;
    typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_t;

    state_t                  state_q, state_d;
    dir_t                    dir_q, dir_d, press_dir;
    logic [N*N*TILE_W-1:0]   board_q, board_d;
    logic [15:0]             score_q, score_d, lfsr_q, lfsr_d;
    logic                    win_q, win_d, lose_q, lose_d, done_q, done_d;
    logic [3:0]              mov_q, mov_d, mov_edge;
    logic [LW-1:0]           line_q, line_d;
    logic                    changed_q, changed_d, second_q, second_d, load_q, load_d;
    logic [CW-1:0]           spawn_idx_q, spawn_idx_d, scan_q, scan_d, start_idx;
    logic [TILE_W-1:0]       spawn_exp_q, spawn_exp_d, new_exp;
    logic                    press, any_win, any_empty, any_pair;

    logic [TILE_W-1:0]       line_in  [N];
    logic [TILE_W-1:0]       packed_l [N+1];
    logic [TILE_W-1:0]       line_out [N];
    logic [31:0]             line_gain;
    logic                    line_chg;
    logic [32:0]             score_sum;

    // Element 0 of a line is the cell the tiles slide toward.
    function automatic int cell_idx(dir_t d, int l, int k);
        case (d)
            D_LEFT:  return l * N + k;
            D_RIGHT: return l * N + (N - 1 - k);
            D_UP:    return k * N + l;
            default: return (N - 1 - k) * N + l;
        endcase
    endfunction

    function automatic logic [TILE_W-1:0] cell_at(logic [N*N*TILE_W-1:0] b, int i);
        return b[i*TILE_W +: TILE_W];
    endfunction

    function automatic logic [31:0] merge_val(logic [TILE_W-1:0] e);
        logic [31:0] p;
        p = 32'(e) + 32'd1;
        return (p >= 32'd16) ? 32'h0001_0000 : (32'd1 << p);
    endfunction

`ifdef GAME_SPAWN_FOUR_EN
    assign new_exp = (lfsr_q[2:0] == 3'b000) ? TILE_W'(2) : TILE_W'(1);
`else
    assign new_exp = TILE_W'(1);
`endif

    assign start_idx = CW'(lfsr_q % 16'(CELLS));
    assign mov_d     = {mov_down, mov_up, mov_right, mov_left};
    assign mov_edge  = mov_d & ~mov_q;
    assign press     = (mov_edge != 4'b0000) && ((mov_edge & (mov_edge - 4'd1)) == 4'b0000);

    always_comb begin
        case (mov_edge)
            4'b0001: press_dir = D_LEFT;
            4'b0010: press_dir = D_RIGHT;
            4'b0100: press_dir = D_UP;
            default: press_dir = D_DOWN;
        endcase
    end

    // Compact the current line toward element 0, then merge pairs outward once each.
    always_comb begin
        int cnt;
        int o;
        logic skip;
        cnt       = 0;
        o         = 0;
        skip      = 1'b0;
        line_gain = '0;
        line_chg  = 1'b0;
        for (int k = 0; k < N; k++) begin
            line_in[k]  = board_q[cell_idx(dir_q, int'(line_q), k)*TILE_W +: TILE_W];
            line_out[k] = '0;
        end
        for (int k = 0; k <= N; k++) packed_l[k] = '0;
        for (int k = 0; k < N; k++) begin
            if (line_in[k] != '0) begin
                packed_l[cnt] = line_in[k];
                cnt++;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (packed_l[k] != '0) begin
                if (packed_l[k] == packed_l[k+1] && packed_l[k] != MAX_EXP) begin
                    line_out[o] = packed_l[k] + TILE_W'(1);
                    line_gain   = line_gain + merge_val(packed_l[k]);
                    skip        = 1'b1;
                end else begin
                    line_out[o] = packed_l[k];
                end
                o++;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (line_out[k] != line_in[k]) line_chg = 1'b1;
        end
        score_sum = 33'(score_q) + 33'(line_gain);
    end

    always_comb begin
        any_win   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if (cell_at(board_q, i) == WIN_T) any_win = 1'b1;
            if (cell_at(board_q, i) == '0) any_empty = 1'b1;
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N - 1; c++)
                if (cell_at(board_q, r*N + c) == cell_at(board_q, r*N + c + 1)) any_pair = 1'b1;
        for (int r = 0; r < N - 1; r++)
            for (int c = 0; c < N; c++)
                if (cell_at(board_q, r*N + c) == cell_at(board_q, (r+1)*N + c)) any_pair = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        board_d     = board_q;
        score_d     = score_q;
        win_d       = win_q;
        lose_d      = lose_q;
        done_d      = 1'b0;
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        line_d      = line_q;
        changed_d   = changed_q;
        second_d    = second_q;
        load_d      = load_q;
        spawn_idx_d = spawn_idx_q;
        scan_d      = scan_q;
        spawn_exp_d = spawn_exp_q;
        case (state_q)
            S_INIT: begin
                spawn_idx_d = start_idx;
                spawn_exp_d = new_exp;
                scan_d      = '0;
                second_d    = 1'b1;
                load_d      = 1'b0;
                state_d     = S_SPAWN;
            end
            S_IDLE: begin
                if (load_en) begin
                    board_d = load_board;
                    load_d  = 1'b1;
                    state_d = S_EVAL;
                end else if (press && !win_q && !lose_q) begin
                    dir_d     = press_dir;
                    line_d    = '0;
                    changed_d = 1'b0;
                    load_d    = 1'b0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                for (int k = 0; k < N; k++)
                    board_d[cell_idx(dir_q, int'(line_q), k)*TILE_W +: TILE_W] = line_out[k];
                score_d = (score_sum > 33'h0_FFFF) ? 16'hFFFF : score_sum[15:0];
                if (line_chg) changed_d = 1'b1;
                line_d = line_q + LW'(1);
                if (line_q == LW'(N - 1)) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (changed_q) begin
                    spawn_idx_d = start_idx;
                    spawn_exp_d = new_exp;
                    scan_d      = '0;
                    second_d    = 1'b0;
                    state_d     = S_SPAWN;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SPAWN: begin
                if (cell_at(board_q, int'(spawn_idx_q)) == '0) begin
                    board_d[int'(spawn_idx_q)*TILE_W +: TILE_W] = spawn_exp_q;
                    if (second_q) begin
                        second_d    = 1'b0;
                        spawn_idx_d = start_idx;
                        spawn_exp_d = new_exp;
                        scan_d      = '0;
                    end else begin
                        state_d = S_EVAL;
                    end
                end else if (scan_q == CW'(CELLS - 1)) begin
                    // Full board: nothing to place, just re-evaluate.
                    second_d = 1'b0;
                    state_d  = S_EVAL;
                end else begin
                    spawn_idx_d = (spawn_idx_q == CW'(CELLS - 1)) ? '0 : spawn_idx_q + CW'(1);
                    scan_d      = scan_q + CW'(1);
                end
            end
            S_EVAL: begin
                win_d   = any_win;
                lose_d  = !any_empty && !any_pair;
                done_d  = !load_q;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_25Mhz) begin
        if (reset) begin
            state_q     <= S_INIT;
            dir_q       <= D_LEFT;
            board_q     <= '0;
            score_q     <= '0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            done_q      <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            mov_q       <= '0;
            line_q      <= '0;
            changed_q   <= 1'b0;
            second_q    <= 1'b0;
            load_q      <= 1'b0;
            spawn_idx_q <= '0;
            scan_q      <= '0;
            spawn_exp_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            board_q     <= board_d;
            score_q     <= score_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            done_q      <= done_d;
            lfsr_q      <= lfsr_d;
            mov_q       <= mov_d;
            line_q      <= line_d;
            changed_q   <= changed_d;
            second_q    <= second_d;
            load_q      <= load_d;
            spawn_idx_q <= spawn_idx_d;
            scan_q      <= scan_d;
            spawn_exp_q <= spawn_exp_d;
        end
    end

    assign board     = board_q;
    assign score     = score_q;
    assign win_flag  = win_q;
    assign lose_flag = lose_q;
    assign move_done = done_q;
    assign busy      = (state_q != S_IDLE) && !reset;
    assign dbg_state = state_q;
endmodule
